ripple_count_monitor: RTL and testbench
=======================================

// Module: ripple_count_monitor
// PURPOSE
//   Consumes the 3-bit output of the TFF ripple counter. Ripple bits settle at
//   different times and are asynchronous to clk, so this block synchronises and
//   de-glitches them, then checks that successive values step by exactly one.
//   It emits step/wrap pulses, keeps a saturating wrap count, raises a threshold
//   interrupt and flags illegal jumps for the system controller.
// PARAMETERS
//   CNT_W        3   width of monitored count
//   WRAP_W       8   width of wrap counter / threshold
//   SYNC_STAGES  2   synchroniser flops on cnt_in (>=2)
//   DOWN         0   0: legal step is +1 (max->0 wraps); 1: legal step is -1 (0->max wraps)
// PORTS
//   clk         in   1       system clock, all flops on posedge
//   reset       in   1       asynchronous, active-low reset
//   en          in   1       1 = monitor; 0 = return to IDLE
//   clr         in   1       sync clear of wrap_count and irq
//   cnt_in      in   CNT_W   raw ripple-counter q bus (asynchronous)
//   thresh      in   WRAP_W  irq threshold; 0 disables irq
//   irq_ack     in   1       clears irq
//   cnt_q       out  CNT_W   last accepted (stable) count
//   step_pulse  out  1       1-cycle pulse per legal step
//   wrap_pulse  out  1       1-cycle pulse per legal wrap
//   wrap_count  out  WRAP_W  saturating count of wraps
//   irq         out  1       sticky threshold interrupt
//   err_skip    out  1       sticky illegal-step flag
//   busy        out  1       1 in ARM/TRACK/FAULT
// BEHAVIOUR
//   Reset (reset=0, async): all outputs 0, sync chain 0, state IDLE.
//   Sync: cnt_in -> SYNC_STAGES flops -> s; prev reg p <= s each cycle.
//     Value accepted when s==p (stable 2 consecutive samples). Shorter glitches
//     are dropped silently.
//   Latency: a value held stable on cnt_in appears on cnt_q, with its pulses,
//     SYNC_STAGES+2 clock edges after it changes.
//   FSM: IDLE  -> ARM on en=1.
//        ARM   -> TRACK on first accepted value: load cnt_q, no pulses.
//        TRACK, accepted v!=cnt_q:
//          v==cnt_q+1 (DOWN=0) or v==cnt_q-1 (DOWN=1), mod 2^CNT_W:
//            cnt_q<=v; step_pulse=1.
//          If it is the wrap (max->0 or 0->max): also wrap_pulse=1 and
//            wrap_count++, which saturates at all-ones.
//          Any other v: cnt_q<=v, err_skip<=1, -> FAULT, no pulses.
//        TRACK, v==cnt_q: nothing.
//        FAULT: cnt_q keeps following accepted values; no pulses.
//        en=0 in any state -> IDLE next edge; err_skip cleared on IDLE entry.
//          cnt_q, wrap_count and irq are held.
//   irq: set on the edge where wrap_count becomes == thresh (thresh!=0).
//     Cleared by irq_ack or clr; a same-cycle set and ack leaves irq=1.
//   clr: wrap_count<=0, irq<=0; clr wins over a same-cycle wrap increment.
//   Pulses are never asserted in IDLE, ARM or FAULT.
// TESTING
//   1 en=1; cnt_in 0,1..7,0, each held 4 clk -> ARM on 0, 8 step_pulse,
//     1 wrap_pulse, wrap_count=1, err_skip=0.
//   2 thresh=2, two full wraps -> irq=1 on 2nd wrap edge; irq_ack -> irq=0 next
//     edge; ack coincident with a set -> irq stays 1.
//   3 in TRACK cnt_q=3, drive 5 -> err_skip=1, FAULT, no step_pulse;
//     en=0 -> IDLE, err_skip=0, wrap_count unchanged.
//   4 cnt_q=2, cnt_in glitch to 6 for 1 clk then 3 -> no fault, 1 step, cnt_q=3.
//   5 DOWN=1, drive 0->7 -> wrap_pulse, wrap_count+1; WRAP_W=8 at 255
//     plus 1 wrap -> stays 255; clr -> 0.
//   6 reset=0 mid-TRACK, asynchronous to clk -> all outputs 0 immediately,
//     IDLE after release.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Synchronises and de-glitches the q bus of a TFF ripple counter, then checks
// that each accepted value is exactly one step (up or down) from the last.
// Legal steps produce step/wrap pulses. Wraps are counted in a saturating
// counter that drives a threshold interrupt. Any other jump raises err_skip.
//
// state | meaning
// IDLE  | monitor off; cnt_q, wrap_count and irq held, err_skip cleared
// ARM   | waiting for the first stable value, which seeds cnt_q
// TRACK | checking each new stable value against cnt_q +/- 1
// FAULT | illegal jump seen; cnt_q follows stable values, no pulses
`timescale 1ns/1ps
module ripple_count_monitor #(
    parameter int CNT_W       = 3,
    parameter int WRAP_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DOWN        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [WRAP_W-1:0] thresh,
    input  logic              irq_ack,
    output logic [CNT_W-1:0]  cnt_q,
    output logic              step_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              irq,
    output logic              err_skip,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    // the wrap happens when stepping off the end of the range in the legal direction
    localparam logic [CNT_W-1:0]  WRAP_FROM = (DOWN != 0) ? '0 : CNT_MAX;

    state_t           state;
    logic [CNT_W-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] prev_q;
    logic [CNT_W-1:0] s_val;
    logic [CNT_W-1:0] step_val;
    logic             accept;
    logic             legal_step;
    logic             wrap_event;
    logic             wrap_inc;
    logic             irq_set;

    assign s_val      = sync_q[SYNC_STAGES-1];
    // two identical consecutive synchronised samples mean the ripple has settled
    assign accept     = (s_val == prev_q);
    assign step_val   = (DOWN != 0) ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
    assign legal_step = en && (state == TRACK) && accept && (s_val != cnt_q) && (s_val == step_val);
    assign wrap_event = legal_step && (cnt_q == WRAP_FROM);
    assign wrap_inc   = wrap_event && (wrap_count != WRAP_MAX);
    assign irq_set    = wrap_inc && (thresh != '0) && ((wrap_count + WRAP_ONE) == thresh);
    assign busy       = (state != IDLE);

    // synchroniser chain plus one-cycle-delayed copy for the stability compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= cnt_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s_val;
        end
    end

    // sequencing FSM with registered count, pulses and skip flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt_q      <= '0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            err_skip   <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                err_skip <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (accept) begin
                            cnt_q <= s_val;
                            state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (accept && (s_val != cnt_q)) begin
                            cnt_q <= s_val;
                            if (s_val == step_val) begin
                                step_pulse <= 1'b1;
                                wrap_pulse <= (cnt_q == WRAP_FROM);
                            end else begin
                                err_skip <= 1'b1;
                                state    <= FAULT;
                            end
                        end
                    end
                    FAULT: begin
                        if (accept) begin
                            cnt_q <= s_val;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // saturating wrap counter and threshold interrupt; clr beats increment, set beats ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_count <= '0;
            irq        <= 1'b0;
        end else if (clr) begin
            wrap_count <= '0;
            irq        <= 1'b0;
        end else begin
            if (wrap_inc) begin
                wrap_count <= wrap_count + WRAP_ONE;
            end
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: an up-counting instance and a
// down-counting instance, with hand-computed expected values.
`timescale 1ns/1ps
module tb_ripple_count_monitor;

    logic       clk = 1'b0;
    logic       reset;

    logic       en, clr, irq_ack;
    logic [2:0] cnt_in;
    logic [7:0] thresh;
    logic [2:0] cnt_q;
    logic       step_pulse, wrap_pulse, irq, err_skip, busy;
    logic [7:0] wrap_count;

    logic       en1, clr1, irq_ack1;
    logic [2:0] cnt_in1;
    logic [7:0] thresh1;
    logic [2:0] cnt_q1;
    logic       step_pulse1, wrap_pulse1, irq1, err_skip1, busy1;
    logic [7:0] wrap_count1;

    int n_chk = 0;
    int n_err = 0;
    int n_step = 0, n_wrap = 0, n_step1 = 0, n_wrap1 = 0;
    int base_s, base_w, base_s1, base_w1;

    always #5 clk = ~clk;

    ripple_count_monitor #(.CNT_W(3), .WRAP_W(8), .SYNC_STAGES(2), .DOWN(0)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .cnt_in(cnt_in),
        .thresh(thresh), .irq_ack(irq_ack), .cnt_q(cnt_q), .step_pulse(step_pulse),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .irq(irq),
        .err_skip(err_skip), .busy(busy)
    );

    ripple_count_monitor #(.CNT_W(3), .WRAP_W(8), .SYNC_STAGES(2), .DOWN(1)) dut_dn (
        .clk(clk), .reset(reset), .en(en1), .clr(clr1), .cnt_in(cnt_in1),
        .thresh(thresh1), .irq_ack(irq_ack1), .cnt_q(cnt_q1), .step_pulse(step_pulse1),
        .wrap_pulse(wrap_pulse1), .wrap_count(wrap_count1), .irq(irq1),
        .err_skip(err_skip1), .busy(busy1)
    );

    always @(negedge clk) begin
        if (step_pulse)  n_step++;
        if (wrap_pulse)  n_wrap++;
        if (step_pulse1) n_step1++;
        if (wrap_pulse1) n_wrap1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [2:0] v, input int n);
        cnt_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive1(input logic [2:0] v, input int n);
        cnt_in1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic up_wrap();
        for (int v = 1; v < 8; v++) drive(3'(v), 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        en = 0; clr = 0; irq_ack = 0; cnt_in = 0; thresh = 0;
        en1 = 0; clr1 = 0; irq_ack1 = 0; cnt_in1 = 0; thresh1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_cnt_q", 32'(cnt_q), 0);
        chk("rst_pulses", 32'({step_pulse, wrap_pulse}), 0);
        chk("rst_wrap_count", 32'(wrap_count), 0);
        chk("rst_flags", 32'({irq, err_skip, busy}), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: full up count 0..7,0
        en = 1;
        repeat (3) @(negedge clk);
        chk("t1_busy", 32'(busy), 1);
        #1;
        base_s = n_step; base_w = n_wrap;
        cnt_in = 3'd1;
        repeat (3) @(negedge clk);
        chk("t1_latency_old", 32'(cnt_q), 0);
        @(negedge clk);
        chk("t1_latency_new", 32'(cnt_q), 1);
        chk("t1_latency_pulse", 32'(step_pulse), 1);
        for (int v = 2; v < 8; v++) drive(3'(v), 4);
        drive(3'd0, 4);
        #1;
        chk("t1_steps", 32'(n_step - base_s), 8);
        chk("t1_wraps", 32'(n_wrap - base_w), 1);
        chk("t1_wrap_count", 32'(wrap_count), 1);
        chk("t1_err_skip", 32'(err_skip), 0);
        chk("t1_cnt_q", 32'(cnt_q), 0);

        // 2: threshold interrupt
        thresh = 8'd2;
        clr = 1; @(negedge clk); clr = 0;
        chk("t2_clr", 32'(wrap_count), 0);
        up_wrap(); drive(3'd0, 4);
        chk("t2_first_wrap", 32'(wrap_count), 1);
        chk("t2_irq_low", 32'(irq), 0);
        up_wrap();
        cnt_in = 3'd0;
        repeat (3) @(negedge clk);
        chk("t2_irq_before", 32'(irq), 0);
        @(negedge clk);
        chk("t2_irq_set", 32'(irq), 1);
        chk("t2_wrap_count", 32'(wrap_count), 2);
        irq_ack = 1; @(negedge clk); irq_ack = 0;
        chk("t2_irq_ack", 32'(irq), 0);
        thresh = 8'd3;
        up_wrap();
        cnt_in = 3'd0;
        repeat (3) @(negedge clk);
        irq_ack = 1; @(negedge clk); irq_ack = 0;
        chk("t2_set_vs_ack", 32'(irq), 1);
        chk("t2_wrap_count3", 32'(wrap_count), 3);
        irq_ack = 1; @(negedge clk); irq_ack = 0;
        chk("t2_irq_ack2", 32'(irq), 0);

        // 3: illegal jump 3 -> 5
        drive(3'd1, 4); drive(3'd2, 4); drive(3'd3, 4);
        chk("t3_cnt_q3", 32'(cnt_q), 3);
        #1;
        base_s = n_step;
        drive(3'd5, 4);
        chk("t3_err_skip", 32'(err_skip), 1);
        chk("t3_cnt_q5", 32'(cnt_q), 5);
        chk("t3_busy", 32'(busy), 1);
        drive(3'd6, 4);
        #1;
        chk("t3_fault_follow", 32'(cnt_q), 6);
        chk("t3_no_steps", 32'(n_step - base_s), 0);
        en = 0; @(negedge clk);
        chk("t3_err_cleared", 32'(err_skip), 0);
        chk("t3_idle", 32'(busy), 0);
        chk("t3_wrap_held", 32'(wrap_count), 3);

        // 4: one-cycle glitch is ignored
        drive(3'd2, 4);
        chk("t4_idle_hold", 32'(cnt_q), 6);
        en = 1;
        repeat (3) @(negedge clk);
        chk("t4_arm_load", 32'(cnt_q), 2);
        #1;
        base_s = n_step;
        cnt_in = 3'd6; @(negedge clk);
        drive(3'd3, 5);
        #1;
        chk("t4_cnt_q", 32'(cnt_q), 3);
        chk("t4_err_skip", 32'(err_skip), 0);
        chk("t4_steps", 32'(n_step - base_s), 1);

        // 5: down counter wrap, saturation and clear
        en1 = 1;
        repeat (3) @(negedge clk);
        chk("t5_busy", 32'(busy1), 1);
        #1;
        base_s1 = n_step1; base_w1 = n_wrap1;
        drive1(3'd7, 4);
        #1;
        chk("t5_wrap_count1", 32'(wrap_count1), 1);
        chk("t5_cnt_q7", 32'(cnt_q1), 7);
        chk("t5_wrap_pulse", 32'(n_wrap1 - base_w1), 1);
        chk("t5_step_pulse", 32'(n_step1 - base_s1), 1);
        for (int k = 0; k < 254; k++) begin
            for (int v = 6; v >= 0; v--) drive1(3'(v), 3);
            drive1(3'd7, 3);
        end
        repeat (2) @(negedge clk);
        chk("t5_wrap_255", 32'(wrap_count1), 255);
        for (int v = 6; v >= 0; v--) drive1(3'(v), 3);
        drive1(3'd7, 3);
        repeat (2) @(negedge clk);
        #1;
        chk("t5_saturate", 32'(wrap_count1), 255);
        chk("t5_wrap_total", 32'(n_wrap1 - base_w1), 256);
        chk("t5_err_skip", 32'(err_skip1), 0);
        chk("t5_irq_disabled", 32'(irq1), 0);
        clr1 = 1; @(negedge clk); clr1 = 0;
        chk("t5_clr", 32'(wrap_count1), 0);

        // 6: asynchronous reset mid-track
        chk("t6_pre_busy", 32'(busy), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_cnt_q", 32'(cnt_q), 0);
        chk("t6_wrap_count", 32'(wrap_count), 0);
        chk("t6_flags", 32'({irq, err_skip, busy, step_pulse, wrap_pulse}), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_idle", 32'(busy), 0);
        @(negedge clk);
        chk("t6_arm", 32'(busy), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
